mips_multicycle_control: RTL and testbench

Main control finite-state machine for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives all datapath enables and mux selects, and issues the 2-bit `alu_op` consumed by the ALU control decoder, which produces the 4-bit ALU function. It sits between the instruction register's opcode field, the memory interface, and the ALU/register-file/PC datapath.

---
 rtl/mips_ctrl_pkg.sv | 65 ++++++
 rtl/mips_ctrl_outdec.sv | 71 +++++++
 rtl/mips_multicycle_control.sv | 96 +++++++++
 tb/tb_mips_multicycle_control.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALU-op classes and datapath select values. The ALU control decoder imports
// this too, so the alu_op encoding is defined only here.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADDR  = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        RWB      = 4'd7,
        EXEC_I   = 4'd8,
        IWB      = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Raw per-state control vector, before mem_ready/reset gating.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control-vector decoder (pure Moore part of the
// control unit). Unused state encodings decode to all-zero controls.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Decode control vector from the current state.
    always_comb begin
        // NOTE: every field gets a default before the case, so no path leaves
        // an output unassigned and no latch is inferred.
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            MEMADDR, EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            IWB: begin
                ctrl.reg_write = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Holds the state
// register and next-state logic, and gates the decoded controls with
// mem_ready (fetch stall) and reset (no writes while reset is high).
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   fetch_stall;

    // State register; reset returns to FETCH asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is written with <= so every flop samples pre-edge values.
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic; op is only looked at in DECODE and MEMADDR.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADDR;
                    OP_RTYPE:     state_d = EXEC_R;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = EXEC_I;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADDR: begin
                if (op == OP_LW)      state_d = MEMREAD;
                else if (op == OP_SW) state_d = MEMWRITE;
                else                  state_d = FETCH;
            end
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXEC_R:   state_d = RWB;
            EXEC_I:   state_d = IWB;
            default:  state_d = FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // A stalled fetch must neither advance the PC nor reload the IR.
    assign fetch_stall = (state_q == FETCH) && !mem_ready;

    // Output gating: write enables are suppressed during reset and fetch stall.
    always_comb begin
        pc_write      = ctrl.pc_write && !fetch_stall && !reset;
        ir_write      = ctrl.ir_write && !fetch_stall && !reset;
        pc_write_cond = ctrl.pc_write_cond && !reset;
        reg_write     = ctrl.reg_write && !reset;
        mem_write     = ctrl.mem_write && !reset;
        i_or_d        = ctrl.i_or_d;
        mem_read      = ctrl.mem_read;
        mem_to_reg    = ctrl.mem_to_reg;
        reg_dst       = ctrl.reg_dst;
        alu_src_a     = ctrl.alu_src_a;
        alu_src_b     = ctrl.alu_src_b;
        alu_op        = ctrl.alu_op;
        pc_source     = ctrl.pc_source;
        illegal_op    = (state_q == DECODE) && !op_supported(op) && !reset;
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: each driven cycle pushes the
// expected state and output vector; a negedge monitor pops and compares.
module tb_mips_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'h00;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, reg_dst, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] vec;
    } sb_item_t;

    sb_item_t sb[$];

    mips_multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Vector layout: {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
    // ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
    // pc_source, illegal_op}
    function automatic logic [31:0] pack(input logic [3:0] st, input logic pcw, input logic pcc,
                                         input logic iod, input logic mr, input logic mw,
                                         input logic irw, input logic m2r, input logic rw,
                                         input logic rd, input logic sa, input logic [1:0] sb_,
                                         input logic [1:0] ao, input logic [1:0] ps,
                                         input logic ill);
        return {11'd0, st, pcw, pcc, iod, mr, mw, irw, m2r, rw, rd, sa, sb_, ao, ps, ill};
    endfunction

    // Reference table of the control unit, written from the state descriptions.
    function automatic logic [31:0] expect_vec(input state_t st, input logic rdy,
                                               input logic [5:0] o, input logic rst);
        logic ok;
        ok = !rst;
        case (st)
            FETCH:    return pack(4'(FETCH), rdy & ok, 0, 0, 1, 0, rdy & ok, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
            DECODE:   return pack(4'(DECODE), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00,
                                  ok & !(o == 6'h00 || o == 6'h23 || o == 6'h2B ||
                                         o == 6'h04 || o == 6'h02 || o == 6'h08));
            MEMADDR:  return pack(4'(MEMADDR), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
            MEMREAD:  return pack(4'(MEMREAD), 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            MEMWB:    return pack(4'(MEMWB), 0, 0, 0, 0, 0, 0, 1, ok, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            MEMWRITE: return pack(4'(MEMWRITE), 0, 0, 1, 0, ok, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            EXEC_R:   return pack(4'(EXEC_R), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
            RWB:      return pack(4'(RWB), 0, 0, 0, 0, 0, 0, 0, ok, 1, 0, 2'b00, 2'b00, 2'b00, 0);
            EXEC_I:   return pack(4'(EXEC_I), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
            IWB:      return pack(4'(IWB), 0, 0, 0, 0, 0, 0, 0, ok, 0, 0, 2'b00, 2'b00, 2'b00, 0);
            BRANCH:   return pack(4'(BRANCH), 0, ok, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
            JUMP:     return pack(4'(JUMP), ok, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Drive one cycle of stimulus just after the edge and queue its expectation.
    task automatic step(input string tag, input state_t st, input logic [5:0] o,
                        input logic rdy, input logic rst);
        sb_item_t it;
        @(posedge clk);
        #1;
        op        = o;
        mem_ready = rdy;
        reset     = rst;
        it.tag    = tag;
        it.vec    = expect_vec(st, rdy, o, rst);
        sb.push_back(it);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_item_t it;
            it = sb.pop_front();
            check(it.tag, pack(state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                               ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
                               alu_src_b, alu_op, pc_source, illegal_op), it.vec);
        end
    end

    initial begin
        // Power-on reset with mem_ready high: no write enables may leak out.
        step("por0", FETCH, 6'h00, 1'b1, 1'b1);
        step("por1", FETCH, 6'h00, 1'b1, 1'b1);

        // R-type, then reset asserted while in EXEC_R.
        step("r_fetch",  FETCH,  6'h00, 1'b1, 1'b0);
        step("r_decode", DECODE, 6'h00, 1'b1, 1'b0);
        step("r_exec",   EXEC_R, 6'h00, 1'b1, 1'b0);
        step("r_wb",     RWB,    6'h00, 1'b1, 1'b0);
        step("r2_fetch",  FETCH,  6'h00, 1'b1, 1'b0);
        step("r2_decode", DECODE, 6'h00, 1'b1, 1'b0);
        step("rst_mid_exec", FETCH, 6'h00, 1'b1, 1'b1);
        step("rst_hold",     FETCH, 6'h00, 1'b1, 1'b1);
        step("rst_release",  FETCH, 6'h00, 1'b1, 1'b0);
        step("rst_decode",   DECODE, 6'h00, 1'b1, 1'b0);
        step("rst_exec",     EXEC_R, 6'h00, 1'b1, 1'b0);
        step("rst_wb",       RWB,    6'h00, 1'b1, 1'b0);

        // lw, no stalls: 5 cycles.
        step("lw_fetch",  FETCH,   6'h23, 1'b1, 1'b0);
        step("lw_decode", DECODE,  6'h23, 1'b1, 1'b0);
        step("lw_addr",   MEMADDR, 6'h23, 1'b1, 1'b0);
        step("lw_read",   MEMREAD, 6'h23, 1'b1, 1'b0);
        step("lw_wb",     MEMWB,   6'h23, 1'b1, 1'b0);

        // lw with one stall cycle in MEMREAD; op changes there and is ignored.
        step("lws_fetch",  FETCH,   6'h23, 1'b1, 1'b0);
        step("lws_decode", DECODE,  6'h23, 1'b1, 1'b0);
        step("lws_addr",   MEMADDR, 6'h23, 1'b1, 1'b0);
        step("lws_read0",  MEMREAD, 6'h3F, 1'b0, 1'b0);
        step("lws_read1",  MEMREAD, 6'h23, 1'b1, 1'b0);
        step("lws_wb",     MEMWB,   6'h23, 1'b1, 1'b0);

        // sw with mem_ready low for 2 cycles in MEMWRITE: 6 cycles.
        step("sw_fetch",  FETCH,    6'h2B, 1'b1, 1'b0);
        step("sw_decode", DECODE,   6'h2B, 1'b1, 1'b0);
        step("sw_addr",   MEMADDR,  6'h2B, 1'b1, 1'b0);
        step("sw_wr0",    MEMWRITE, 6'h2B, 1'b0, 1'b0);
        step("sw_wr1",    MEMWRITE, 6'h2B, 1'b0, 1'b0);
        step("sw_wr2",    MEMWRITE, 6'h2B, 1'b1, 1'b0);

        // beq and j: 3 cycles each.
        step("beq_fetch",  FETCH,  6'h04, 1'b1, 1'b0);
        step("beq_decode", DECODE, 6'h04, 1'b1, 1'b0);
        step("beq_branch", BRANCH, 6'h04, 1'b1, 1'b0);
        step("j_fetch",    FETCH,  6'h02, 1'b1, 1'b0);
        step("j_decode",   DECODE, 6'h02, 1'b1, 1'b0);
        step("j_jump",     JUMP,   6'h02, 1'b1, 1'b0);

        // addi: 4 cycles.
        step("addi_fetch",  FETCH,  6'h08, 1'b1, 1'b0);
        step("addi_decode", DECODE, 6'h08, 1'b1, 1'b0);
        step("addi_exec",   EXEC_I, 6'h08, 1'b1, 1'b0);
        step("addi_wb",     IWB,    6'h08, 1'b1, 1'b0);

        // Fetch stalled 3 cycles, then an illegal opcode bounces back to FETCH.
        step("stall0",  FETCH,  6'h3F, 1'b0, 1'b0);
        step("stall1",  FETCH,  6'h3F, 1'b0, 1'b0);
        step("stall2",  FETCH,  6'h3F, 1'b0, 1'b0);
        step("stall3",  FETCH,  6'h3F, 1'b1, 1'b0);
        step("ill_dec", DECODE, 6'h3F, 1'b1, 1'b0);
        step("ill_ret", FETCH,  6'h3F, 1'b1, 1'b0);

        // sw abandoned by reset during MEMWRITE: no write while reset high.
        step("swr_decode", DECODE,   6'h2B, 1'b1, 1'b0);
        step("swr_addr",   MEMADDR,  6'h2B, 1'b1, 1'b0);
        step("swr_wr",     MEMWRITE, 6'h2B, 1'b0, 1'b0);
        step("swr_rst",    FETCH,    6'h2B, 1'b0, 1'b1);
        step("swr_rel",    FETCH,    6'h2B, 1'b0, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
